// File: rtl/term_pkg.sv
// Shared FSM states, command codes and printable range for the text buffer controller.
package term_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD_ADDR,
    RD_WAIT,
    SEND,
    REF_RD,
    REF_WAIT,
    REF_SEND
  } state_t;

  localparam logic [7:0] CMD_LEFT    = 8'h68;  // 'h'
  localparam logic [7:0] CMD_DOWN    = 8'h6A;  // 'j'
  localparam logic [7:0] CMD_UP      = 8'h6B;  // 'k'
  localparam logic [7:0] CMD_RIGHT   = 8'h6C;  // 'l'
  localparam logic [7:0] CMD_CR      = 8'h0D;
  localparam logic [7:0] CMD_REFRESH = 8'h20;

  localparam logic [7:0] PRINT_LO = 8'h21;
  localparam logic [7:0] PRINT_HI = 8'h7E;

endpackage

// File: rtl/term_ram.sv
// Single-port synchronous RAM, registered read (1 cycle), write-first, contents not reset.
module term_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 960,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/term_buffer_ctrl.sv
// Character-cell screen buffer with cursor: executes byte commands and streams echo/refresh bytes.
// Echo appears 2 cycles after accept; output is held under backpressure and input is only taken in IDLE.
module term_buffer_ctrl import term_pkg::*; #(
  parameter int                 COLS           = 40,
  parameter int                 ROWS           = 24,
  parameter int                 DATA_W         = 8,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  FILL_CHAR      = DATA_W'(8'h20),
  localparam int                DEPTH          = COLS * ROWS,
  localparam int                ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_busy
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COLS_X  = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W:0]   ONE_X   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  // Sums are formed one bit wider and folded back explicitly, since DEPTH is rarely a power of 2.
  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W:0] v);
    return (v >= DEPTH_X) ? ADDR_W'(v - DEPTH_X) : ADDR_W'(v);
  endfunction

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cursor, ptr;
  logic [DATA_W-1:0] byte_q;
  logic              wr_cmd;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic is_left, is_right, is_up, is_down, is_move, is_cr, is_ref, is_print;
  logic [ADDR_W:0]   cur_x;
  logic [ADDR_W-1:0] cur_right, move_cur;

  assign is_left  = (i_data == DATA_W'(CMD_LEFT));
  assign is_right = (i_data == DATA_W'(CMD_RIGHT));
  assign is_up    = (i_data == DATA_W'(CMD_UP));
  assign is_down  = (i_data == DATA_W'(CMD_DOWN));
  assign is_move  = is_left | is_right | is_up | is_down;
  assign is_cr    = (i_data == DATA_W'(CMD_CR));
  assign is_ref   = (i_data == DATA_W'(CMD_REFRESH));
  assign is_print = (i_data >= DATA_W'(PRINT_LO)) && (i_data <= DATA_W'(PRINT_HI)) && !is_move;

  assign cur_x     = {1'b0, cursor};
  assign cur_right = wrap(cur_x + ONE_X);

  always_comb begin
    move_cur = cursor;
    if (is_left)       move_cur = wrap(cur_x + DEPTH_X - ONE_X);
    else if (is_right) move_cur = cur_right;
    else if (is_up)    move_cur = wrap(cur_x + DEPTH_X - COLS_X);
    else if (is_down)  move_cur = wrap(cur_x + COLS_X);
    else if (is_cr)    move_cur = ADDR_W'(cur_x - (cur_x % COLS_X));
  end

  assign o_ready  = (state == IDLE) && !rst;
  assign o_busy   = (state != IDLE) || rst;
  assign o_cursor = cursor;

  always_ff @(posedge clk) begin
    if (rst) state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = cursor;
    ram_wdata = byte_q;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = ptr;
        ram_wdata = FILL_CHAR;
        if (ptr == LAST) state_nxt = IDLE;
      end
      IDLE: begin
        if (i_valid) begin
          if (is_move || is_print) state_nxt = RD_ADDR;
          else if (is_ref)         state_nxt = REF_RD;
        end
      end
      RD_ADDR: begin
        // A write command spends this cycle writing; its echo comes from byte_q, not the RAM.
        ram_we    = wr_cmd;
        state_nxt = RD_WAIT;
      end
      RD_WAIT:  state_nxt = SEND;
      SEND:     if (i_ready) state_nxt = IDLE;
      REF_RD: begin
        ram_addr  = ptr;
        state_nxt = REF_WAIT;
      end
      REF_WAIT: state_nxt = REF_SEND;
      REF_SEND: if (i_ready) state_nxt = (ptr == LAST) ? IDLE : REF_RD;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor  <= '0;
      ptr     <= '0;
      byte_q  <= '0;
      wr_cmd  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      case (state)
        CLEAR: ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        IDLE: begin
          if (i_valid) begin
            byte_q <= i_data;
            wr_cmd <= is_print;
            ptr    <= '0;
            cursor <= move_cur;
          end
        end
        RD_ADDR: if (wr_cmd) cursor <= cur_right;
        RD_WAIT: begin
          o_valid <= 1'b1;
          o_data  <= wr_cmd ? byte_q : ram_rdata;
        end
        SEND: if (i_ready) o_valid <= 1'b0;
        REF_WAIT: begin
          o_valid <= 1'b1;
          o_data  <= ram_rdata;
        end
        REF_SEND: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            ptr     <= (ptr == LAST) ? '0 : ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  term_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_term_buffer_ctrl.sv
// Directed + random command stream against a screen/cursor reference model, with random output backpressure.
module tb_term_buffer_ctrl;
  import term_pkg::*;

  localparam int COLS  = 40;
  localparam int ROWS  = 24;
  localparam int DEPTH = COLS * ROWS;

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [9:0] o_cursor;
  logic       o_busy;

  int vectors;
  int miscompares;

  logic [7:0] mem [DEPTH];
  int         mcur;

  term_buffer_ctrl #(
    .COLS           (COLS),
    .ROWS           (ROWS),
    .DATA_W         (8),
    .CLEAR_ON_RESET (1),
    .FILL_CHAR      (8'h20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_cursor (o_cursor),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one non-refresh command, straight from the command table.
  task automatic model_cmd(input logic [7:0] b, output logic echo, output logic [7:0] eb);
    echo = 1'b0;
    eb   = 8'h00;
    if (b == CMD_LEFT) begin
      mcur = (mcur + DEPTH - 1) % DEPTH; echo = 1'b1; eb = mem[mcur];
    end else if (b == CMD_RIGHT) begin
      mcur = (mcur + 1) % DEPTH; echo = 1'b1; eb = mem[mcur];
    end else if (b == CMD_UP) begin
      mcur = (mcur + DEPTH - COLS) % DEPTH; echo = 1'b1; eb = mem[mcur];
    end else if (b == CMD_DOWN) begin
      mcur = (mcur + COLS) % DEPTH; echo = 1'b1; eb = mem[mcur];
    end else if (b == CMD_CR) begin
      mcur = (mcur / COLS) * COLS;
    end else if (b >= 8'h21 && b <= 8'h7E) begin
      mem[mcur] = b; echo = 1'b1; eb = b;
      mcur = (mcur + 1) % DEPTH;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("ready_timeout", {31'd0, o_ready}, 32'd1);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] b);
    logic       echo;
    logic [7:0] eb;
    logic       early;
    i_ready = 1'b1;
    early = !(b >= 8'h21 && b <= 8'h7E) || b == CMD_LEFT || b == CMD_RIGHT ||
            b == CMD_UP || b == CMD_DOWN;
    model_cmd(b, echo, eb);
    send_cmd(b);
    if (early) check($sformatf("cursor_at_accept_%0h", b), 32'(o_cursor), mcur);
    @(negedge clk);
    check("valid_cycle0", {31'd0, o_valid}, 32'd0);
    check("busy_cycle0", {31'd0, o_busy}, {31'd0, echo});
    @(negedge clk);
    check("valid_cycle1", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("valid_cycle2_%0h", b), {31'd0, o_valid}, {31'd0, echo});
    if (echo) check($sformatf("echo_%0h", b), 32'(o_data), 32'(eb));
    @(negedge clk);
    check("valid_after_xfer", {31'd0, o_valid}, 32'd0);
    check($sformatf("cursor_%0h", b), 32'(o_cursor), mcur);
    check("idle_after_cmd", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic do_reset();
    int n;
    rst     = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_cursor", 32'(o_cursor), 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h20;
    mcur = 0;
    check("clear_busy", {31'd0, o_busy}, 32'd1);
    n = 0;
    while (o_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("clear_cycles", n, DEPTH);
    check("clear_done_busy", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic do_refresh(input bit rand_rdy, input int abort_at, input string tag);
    int         got, cyc;
    logic       stalled, aborted, rdy;
    logic [7:0] held;
    got = 0; cyc = 0; stalled = 1'b0; aborted = 1'b0; held = 8'h00;
    i_ready = 1'b1;
    send_cmd(CMD_REFRESH);
    while (got < DEPTH && cyc < 20000 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check({tag, "_stall_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_stall_data"}, 32'(o_data), 32'(held));
      end
      if (abort_at >= 0 && got == abort_at && o_valid === 1'b1) begin
        i_ready = 1'b0;
        aborted = 1'b1;
      end else begin
        rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        i_ready = rdy;
        if (o_valid === 1'b1 && rdy) begin
          check($sformatf("%s[%0d]", tag, got), 32'(o_data), 32'(mem[got]));
          got++;
        end
        stalled = (o_valid === 1'b1) && !rdy;
        held    = o_data;
      end
    end
    if (abort_at >= 0) begin
      check({tag, "_reached_abort"}, {31'd0, aborted}, 32'd1);
    end else begin
      check({tag, "_count"}, got, DEPTH);
      if (!rand_rdy) check({tag, "_cycles"}, cyc, 3 * DEPTH);
      i_ready = 1'b1;
      @(negedge clk);
      check({tag, "_no_extra"}, {31'd0, o_valid}, 32'd0);
      check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
      check({tag, "_cursor"}, 32'(o_cursor), mcur);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_data      = 8'h00;
    i_ready     = 1'b1;
    mcur        = 0;

    do_reset();
    do_refresh(1'b0, -1, "ref_clear");

    do_cmd(8'h41);
    check("A_cursor", 32'(o_cursor), 32'd1);
    do_cmd(CMD_LEFT);
    check("h_cursor", 32'(o_cursor), 32'd0);

    do_cmd(CMD_UP);
    check("k_wrap", 32'(o_cursor), 32'd920);
    do_cmd(CMD_DOWN);
    check("j_wrap", 32'(o_cursor), 32'd0);
    do_cmd(CMD_LEFT);
    check("h_wrap", 32'(o_cursor), 32'd959);
    do_cmd(CMD_RIGHT);
    check("l_wrap", 32'(o_cursor), 32'd0);

    do_cmd(CMD_LEFT);
    do_cmd(8'h58);
    check("X_wrap", 32'(o_cursor), 32'd0);
    do_cmd(CMD_DOWN);
    repeat (5) do_cmd(CMD_RIGHT);
    check("at_45", 32'(o_cursor), 32'd45);
    do_cmd(CMD_CR);
    check("cr_col0", 32'(o_cursor), 32'd40);
    do_cmd(8'h01);

    do_cmd(CMD_UP);
    do_cmd(8'h48);
    do_cmd(8'h49);
    do_refresh(1'b1, -1, "ref_hi");

    for (int i = 0; i < 60; i++) begin
      int         r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0: b = CMD_LEFT;
        1: b = CMD_RIGHT;
        2: b = CMD_UP;
        3: b = CMD_DOWN;
        4: b = CMD_CR;
        5, 6, 7: b = 8'($urandom_range(33, 126));
        default: begin
          b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
          if (b == CMD_CR) b = 8'h00;
        end
      endcase
      do_cmd(b);
    end
    do_refresh(1'b1, -1, "ref_rand");

    do_refresh(1'b1, 300, "ref_abort");
    do_reset();
    do_refresh(1'b0, -1, "ref_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/term_buffer_ctrl.md
Name: term_buffer_ctrl

Overview:
- Parametrised character-cell text buffer controller between the serial byte receiver and the serial transmitter.
- Holds a COLS x ROWS screen in a single-port RAM and tracks a cursor.
- Executes byte commands: cursor moves, character writes, carriage return and full-screen refresh.
- Streams response bytes out through a valid/ready handshake. Correctly accounts for the RAM's 1-cycle read latency and supports backpressure.

Parameters:
- COLS, 40, characters per row (>=2)
- ROWS, 24, rows per screen (>=2)
- DATA_W, 8, character width in bits
- CLEAR_ON_RESET, 1, when 1 the RAM is swept with FILL_CHAR after reset
- FILL_CHAR, 8'h20, value written during the clear sweep
- Derived localparams: DEPTH = COLS*ROWS; ADDR_W = $clog2(DEPTH)

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous, active-high reset
- i_data, input, DATA_W, command/character byte in
- i_valid, input, 1, i_data valid
- o_ready, output, 1, block accepts i_data this cycle
- o_data, output, DATA_W, response byte out
- o_valid, output, 1, o_data valid
- i_ready, input, 1, downstream accepts o_data
- o_cursor, output, ADDR_W, current cursor address (row*COLS+col)
- o_busy, output, 1, high in any state other than IDLE

Behaviour:
- Reset values: o_valid=0, o_data=0, o_cursor=0, o_ready=0, o_busy=1.
- After reset, state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- rst asserted in any state aborts the operation in progress. o_valid drops on the next edge. The cursor and the RAM sweep pointer go to 0.
- Input accept occurs on a cycle with i_valid & o_ready. o_ready=1 only in IDLE.
- Output transfer occurs on a cycle with o_valid & i_ready. While o_valid=1 and i_ready=0, o_data holds stable.
- CLEAR state:
  - Writes FILL_CHAR to addresses 0..DEPTH-1, one per cycle, taking DEPTH cycles.
  - Then enters IDLE.
- Command decode in IDLE:
  - 'h': cursor-1; wraps from 0 to DEPTH-1.
  - 'l': cursor+1; wraps from DEPTH-1 to 0.
  - 'k': cursor-COLS; from row 0, goes to the same column of row ROWS-1.
  - 'j': cursor+COLS; from row ROWS-1, goes to the same column of row 0.
  - For h/j/k/l: the cursor updates on the accept edge, then the block reads RAM at the new cursor and echoes that byte.
  - 0x0D (CR): cursor moves to column 0 of the current row. No output byte.
  - ' ' (0x20): starts a refresh.
  - 0x21..0x7E except h/j/k/l: write the byte at the cursor, then advance the cursor as for 'l', then echo the written byte.
  - Any other byte: consumed and ignored. No output, no state change.
- Echo latency: o_valid rises exactly 2 cycles after the accept edge. Path is RD_ADDR -> RD_WAIT -> SEND.
- SEND state: on transfer, returns to IDLE, or advances the refresh.
- Refresh sequence:
  - For a = 0..DEPTH-1: REF_RD(a) -> REF_WAIT -> REF_SEND.
  - REF_SEND holds until transfer.
  - After the DEPTH-1 transfer, return to IDLE. The cursor is unchanged.
- Throughput: with i_ready=1, one byte every 3 cycles.
- Address arithmetic:
  - Computed at ADDR_W+1 bits, then explicitly wrapped into 0..DEPTH-1.
  - DEPTH need not be a power of 2, so no implicit modular wrap is used.
- The RAM has a single port: write and read are never issued in the same cycle. A write command uses one write cycle, then the echo comes from the registered byte, with no RAM read.
- The block never drops or duplicates output bytes under any i_ready pattern.

Decomposition:
- Shared package term_pkg holds:
  - the state enum (CLEAR, IDLE, RD_ADDR, RD_WAIT, SEND, REF_RD, REF_WAIT, REF_SEND);
  - command constants CMD_LEFT/DOWN/UP/RIGHT/CR/REFRESH;
  - the printable range bounds.
- One sub-module, term_ram: single-port synchronous RAM with parameters DATA_W and DEPTH, 1-cycle registered read, write-first, no reset of contents.

Test Plan:
1. rst for 2 cycles, CLEAR_ON_RESET=1 -> o_busy high, o_ready low for 960 cycles. Then send ' ' -> exactly 960 bytes, all 0x20, then o_busy=0.
2. After clear, send 'A' -> echo 0x41, cursor 1. Send 'h' -> cursor 0, echo 0x41 with o_valid exactly 2 cycles after accept.
3. Wrap: at cursor 0 send 'k' -> cursor 920. Send 'j' -> cursor 0. Send 'h' -> cursor 959. Send 'l' -> cursor 0.
4. Write 'X' at cursor 959 -> cursor 0. Cursor 45, send 0x0D -> cursor 40, no o_valid pulse. Send 0x01 -> ignored, no output.
5. Refresh with random i_ready (~50%) after writing "HI" at 0 -> 960-byte stream beginning 0x48,0x49,0x20..., no drops or duplicates, o_data stable while stalled.
6. rst asserted mid-refresh at byte 300 -> o_valid=0 next cycle, cursor 0, CLEAR re-runs. A following refresh returns all 0x20.
